// File: rtl/cycle_timer_pkg.sv
// -----------------------------------------------------------------------------
// cpu_timing_pkg
// Purpose : shared timing definitions for the CPU cycle timer.
//   - tstate_t and the T0..T6 state codes
//   - cyc_len(): clk periods per CPU cycle for a given phase/gap setting
// -----------------------------------------------------------------------------
package cpu_timing_pkg;

  typedef logic [2:0] tstate_t;

  localparam tstate_t T0 = 3'd0;
  localparam tstate_t T1 = 3'd1;
  localparam tstate_t T2 = 3'd2;
  localparam tstate_t T3 = 3'd3;
  localparam tstate_t T4 = 3'd4;
  localparam tstate_t T5 = 3'd5;
  localparam tstate_t T6 = 3'd6;

  // One CPU cycle = phi1 + gap + phi2 + gap.
  function automatic int cyc_len(input int phase_len, input int gap);
    return 2 * (phase_len + gap);
  endfunction

endpackage

// File: rtl/cycle_timer_if.sv
// -----------------------------------------------------------------------------
// cycle_timer_if
// Purpose : groups the cycle timer's CPU-facing signals.
//   CPU -> timer : rdy, rw, end_instr
//   timer -> CPU : phi1, phi2, dl_load, ir_load, cycle_end, tstate, sync,
//                  stalled, timing_err
// Modports: master = CPU/decode side, slave = cycle timer side.
// -----------------------------------------------------------------------------
interface cycle_timer_if;
  import cpu_timing_pkg::*;

  logic    rdy;
  logic    rw;
  logic    end_instr;
  logic    phi1;
  logic    phi2;
  logic    dl_load;
  logic    ir_load;
  logic    cycle_end;
  tstate_t tstate;
  logic    sync;
  logic    stalled;
  logic    timing_err;

  modport master (
    output rdy, rw, end_instr,
    input  phi1, phi2, dl_load, ir_load, cycle_end, tstate, sync, stalled,
           timing_err
  );

  modport slave (
    input  rdy, rw, end_instr,
    output phi1, phi2, dl_load, ir_load, cycle_end, tstate, sync, stalled,
           timing_err
  );

endinterface

// File: rtl/cycle_timer_phase_counter.sv
// -----------------------------------------------------------------------------
// phase_counter
// Purpose : modulo-CYC clk counter that positions every clk within a CPU cycle.
// Ports   : clk   - system clock
//           rst_n - asynchronous active-low reset (count loads CYC-1)
//           cnt   - current count, 0..CYC-1
//           wrap  - high while cnt == CYC-1 (next edge returns to 0)
// -----------------------------------------------------------------------------
module phase_counter #(
  parameter  int CYC = 6,
  localparam int CW  = $clog2(CYC)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  localparam logic [CW-1:0] C_LAST = CW'(CYC - 1);

  logic [CW-1:0] r_cnt;

  // Resetting to the last count makes the first edge after release land on 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= C_LAST;
    end else if (r_cnt == C_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign cnt  = r_cnt;
  assign wrap = (r_cnt == C_LAST);

endmodule

// File: rtl/cycle_timer.sv
// -----------------------------------------------------------------------------
// cycle_timer
// Purpose : generates non-overlapping phi1/phi2 enables, the data-latch and
//           instruction-register load strobes, and sequences T0..T6 with
//           SYNC, RDY read stalls and instruction-end restart.
// Ports   : clk   - system clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - cycle_timer_if.slave (rdy/rw/end_instr in, phases,
//                   strobes and T-state status out)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module cycle_timer
  import cpu_timing_pkg::*;
#(
  parameter int PHASE_LEN = 2,
  parameter int GAP       = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  cycle_timer_if.slave bus
);

  localparam int CYC = cyc_len(PHASE_LEN, GAP);
  localparam int CW  = $clog2(CYC);

  localparam int C_PHI2_ON   = PHASE_LEN + GAP;
  localparam int C_PHI2_LAST = 2 * PHASE_LEN + GAP - 1;

  logic [CW-1:0] w_cnt;
  logic          w_wrap;
  logic [CW-1:0] w_cnt_next;
  int            w_c;
  logic          w_decide;

  logic    r_first;
  logic    r_phi1, r_phi2, r_dl_load, r_ir_load, r_cycle_end;
  tstate_t r_tstate;
  logic    r_sync, r_stalled, r_timing_err;

  tstate_t w_tstate_next;
  logic    w_sync_next, w_stalled_next, w_err_next;

  phase_counter #(.CYC(CYC)) u_phase_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (w_cnt),
    .wrap  (w_wrap)
  );

  // Outputs are registered, so they are decoded from the count the counter
  // is about to take; that keeps each output aligned with its own clk's c.
  assign w_cnt_next = w_wrap ? '0 : w_cnt + CW'(1);
  assign w_c        = int'(w_cnt_next);

  // The wrap right after reset release only starts the first cycle.
  assign w_decide = w_wrap && !r_first;

  always_comb begin
    w_tstate_next  = r_tstate;
    w_sync_next    = r_sync;
    w_stalled_next = r_stalled;
    w_err_next     = r_timing_err;
    if (w_decide) begin
      if (!bus.rdy && bus.rw) begin
        // Read stall: repeat this cycle, end_instr is not acted on.
        w_stalled_next = 1'b1;
      end else begin
        w_stalled_next = 1'b0;
        if (bus.end_instr) begin
          w_tstate_next = T1;
        end else if (r_tstate == T6) begin
          w_err_next = 1'b1;
        end else begin
          w_tstate_next = r_tstate + 3'd1;
        end
      end
      w_sync_next = (w_tstate_next == T1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first      <= 1'b1;
      r_phi1       <= 1'b0;
      r_phi2       <= 1'b0;
      r_dl_load    <= 1'b0;
      r_ir_load    <= 1'b0;
      r_cycle_end  <= 1'b0;
      r_tstate     <= T0;
      r_sync       <= 1'b0;
      r_stalled    <= 1'b0;
      r_timing_err <= 1'b0;
    end else begin
      r_first      <= 1'b0;
      r_phi1       <= (w_c < PHASE_LEN);
      r_phi2       <= (w_c >= C_PHI2_ON) && (w_c <= C_PHI2_LAST);
      r_dl_load    <= (w_c == C_PHI2_LAST);
      // sync/stalled only change at the wrap, never on the strobe edge.
      r_ir_load    <= (w_c == C_PHI2_LAST) && r_sync && !r_stalled;
      r_cycle_end  <= (w_c == CYC - 1);
      r_tstate     <= w_tstate_next;
      r_sync       <= w_sync_next;
      r_stalled    <= w_stalled_next;
      r_timing_err <= w_err_next;
    end
  end

  assign bus.phi1       = r_phi1;
  assign bus.phi2       = r_phi2;
  assign bus.dl_load    = r_dl_load;
  assign bus.ir_load    = r_ir_load;
  assign bus.cycle_end  = r_cycle_end;
  assign bus.tstate     = r_tstate;
  assign bus.sync       = r_sync;
  assign bus.stalled    = r_stalled;
  assign bus.timing_err = r_timing_err;

endmodule

// File: tb/tb_cycle_timer.sv
// -----------------------------------------------------------------------------
// tb_cycle_timer
// Purpose : self-checking bench for cycle_timer. Two instances run side by
//           side: defaults (CYC=6) and PHASE_LEN=1/GAP=0 (CYC=2). A reference
//           model predicts every output per clk; predictions go into a
//           scoreboard queue and are compared once the DUT has clocked.
// -----------------------------------------------------------------------------
module tb_cycle_timer;
  import cpu_timing_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cycle_timer_if u_if0 ();
  cycle_timer_if u_if1 ();

  cycle_timer #(.PHASE_LEN(2), .GAP(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(u_if0.slave)
  );
  cycle_timer #(.PHASE_LEN(1), .GAP(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(u_if1.slave)
  );

  int errors = 0;
  int checks = 0;
  int ir_cnt0 = 0;
  int dl_cnt0 = 0;
  logic v_rdy, v_rw, v_end;

  typedef struct {
    int cnt;
    bit first;
    bit active;
    int ts;
    bit sync;
    bit stalled;
    bit err;
  } mst_t;

  typedef struct {
    int         dut;
    logic [10:0] v;
  } exp_t;

  mst_t m0, m1;
  exp_t sb[$];

  function automatic mst_t m_reset(input int pl, input int gap);
    mst_t s;
    s.cnt = 2 * (pl + gap) - 1;
    s.first = 1'b1;
    s.active = 1'b0;
    s.ts = 0;
    s.sync = 1'b0;
    s.stalled = 1'b0;
    s.err = 1'b0;
    return s;
  endfunction

  // Expected {phi1,phi2,dl_load,ir_load,cycle_end,tstate,sync,stalled,err}.
  function automatic logic [10:0] m_out(input mst_t s, input int pl, input int gap);
    logic p1, p2, dl, ir, ce;
    int cyc;
    cyc = 2 * (pl + gap);
    if (!s.active) return {5'b0, 3'(s.ts), s.sync, s.stalled, s.err};
    p1 = (s.cnt < pl);
    p2 = (s.cnt >= pl + gap) && (s.cnt < 2 * pl + gap);
    dl = (s.cnt == 2 * pl + gap - 1);
    ir = dl && s.sync && !s.stalled;
    ce = (s.cnt == cyc - 1);
    return {p1, p2, dl, ir, ce, 3'(s.ts), s.sync, s.stalled, s.err};
  endfunction

  function automatic mst_t m_next(input mst_t s, input int pl, input int gap,
                                  input logic rdy, input logic rw,
                                  input logic endi, input logic rstn);
    mst_t n;
    int cyc;
    cyc = 2 * (pl + gap);
    if (!rstn) return m_reset(pl, gap);
    n = s;
    n.active = 1'b1;
    n.first = 1'b0;
    n.cnt = (s.cnt == cyc - 1) ? 0 : s.cnt + 1;
    if (!s.first && s.cnt == cyc - 1) begin
      if (!rdy && rw) begin
        n.stalled = 1'b1;
      end else begin
        n.stalled = 1'b0;
        if (endi) n.ts = 1;
        else if (s.ts == 6) n.err = 1'b1;
        else n.ts = s.ts + 1;
        n.sync = (n.ts == 1);
      end
    end
    return n;
  endfunction

  function automatic logic [10:0] obs(input int d);
    if (d == 0)
      return {u_if0.phi1, u_if0.phi2, u_if0.dl_load, u_if0.ir_load, u_if0.cycle_end,
              u_if0.tstate, u_if0.sync, u_if0.stalled, u_if0.timing_err};
    return {u_if1.phi1, u_if1.phi2, u_if1.dl_load, u_if1.ir_load, u_if1.cycle_end,
            u_if1.tstate, u_if1.sync, u_if1.stalled, u_if1.timing_err};
  endfunction

  task automatic set_in(input logic r, input logic w, input logic e);
    v_rdy = r; v_rw = w; v_end = e;
    u_if0.rdy = r; u_if0.rw = w; u_if0.end_instr = e;
    u_if1.rdy = r; u_if1.rw = w; u_if1.end_instr = e;
  endtask

  task automatic push_exp();
    sb.push_back('{0, m_out(m0, 2, 1)});
    sb.push_back('{1, m_out(m1, 1, 0)});
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    logic [10:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.dut);
      checks++;
      assert (o === e.v) else begin
        errors++;
        $error("FAIL %s dut%0d observed=%b expected=%b", tag, e.dut, o, e.v);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // One clk: predict, clock, then compare away from the edge.
  task automatic step(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      m0 = m_next(m0, 2, 1, v_rdy, v_rw, v_end, rst_n);
      m1 = m_next(m1, 1, 0, v_rdy, v_rw, v_end, rst_n);
      push_exp();
      @(posedge clk);
      #1;
      pop_cmp(tag);
      if (u_if0.ir_load === 1'b1) ir_cnt0++;
      if (u_if0.dl_load === 1'b1) dl_cnt0++;
      checks++;
      assert (!(u_if0.phi1 && u_if0.phi2) && !(u_if1.phi1 && u_if1.phi2)) else begin
        errors++;
        $error("FAIL overlap phi1/phi2 both high dut0=%b%b dut1=%b%b",
               u_if0.phi1, u_if0.phi2, u_if1.phi1, u_if1.phi2);
      end
    end
  endtask

  initial begin
    set_in(1'b1, 1'b1, 1'b0);
    m0 = m_reset(2, 1);
    m1 = m_reset(1, 0);
    #1 rst_n = 1'b0;
    #1;
    push_exp();
    pop_cmp("reset");
    step(2, "in_reset");
    rst_n = 1'b1;

    // First edge: counter to 0, T0, phi1 up.
    step(1, "first_edge");
    chk("first_phi1", 8'(u_if0.phi1), 8'd1);
    chk("first_tstate", 8'(u_if0.tstate), 8'd0);

    // Free run T0..T6 then a second T6.
    step(36, "run");
    chk("t6_first", 8'(u_if0.tstate), 8'd6);
    chk("t6_err_low", 8'(u_if0.timing_err), 8'd0);
    step(6, "run");
    chk("t6_second", 8'(u_if0.tstate), 8'd6);
    chk("t6_err_set", 8'(u_if0.timing_err), 8'd1);

    // Restart from T6, then end_instr during T2.
    set_in(1'b1, 1'b1, 1'b1);
    step(6, "restart");
    chk("restart_t1", 8'(u_if0.tstate), 8'd1);
    set_in(1'b1, 1'b1, 1'b0);
    step(6, "t2");
    set_in(1'b1, 1'b1, 1'b1);
    step(6, "end_t2");
    chk("end_t2_ts", 8'(u_if0.tstate), 8'd1);
    chk("end_t2_sync", 8'(u_if0.sync), 8'd1);
    set_in(1'b1, 1'b1, 1'b0);
    ir_cnt0 = 0;
    step(6, "t1_ir");
    chk("t1_ir_once", 8'(ir_cnt0), 8'd1);
    chk("after_t1_ts", 8'(u_if0.tstate), 8'd2);

    // Read stall in T1 for three repeat cycles.
    set_in(1'b1, 1'b1, 1'b1);
    step(6, "to_t1");
    set_in(1'b0, 1'b1, 1'b0);
    step(6, "stall");
    chk("stall1_ts", 8'(u_if0.tstate), 8'd1);
    chk("stall1_flag", 8'(u_if0.stalled), 8'd1);
    ir_cnt0 = 0;
    dl_cnt0 = 0;
    step(12, "stall");
    set_in(1'b1, 1'b1, 1'b0);
    step(6, "stall_end");
    chk("stall_ir_none", 8'(ir_cnt0), 8'd0);
    chk("stall_dl_each", 8'(dl_cnt0), 8'd3);
    chk("unstall_ts", 8'(u_if0.tstate), 8'd2);
    chk("unstall_flag", 8'(u_if0.stalled), 8'd0);

    // Write cycle ignores rdy.
    step(6, "t3");
    set_in(1'b0, 1'b0, 1'b0);
    step(6, "write");
    chk("write_ts", 8'(u_if0.tstate), 8'd4);
    chk("write_stalled", 8'(u_if0.stalled), 8'd0);
    set_in(1'b1, 1'b1, 1'b0);

    // Asynchronous reset at c=3 of T4.
    step(3, "t4");
    chk("pre_rst_phi2", 8'(u_if0.phi2), 8'd1);
    rst_n = 1'b0;
    #1;
    m0 = m_reset(2, 1);
    m1 = m_reset(1, 0);
    push_exp();
    pop_cmp("async_rst");
    chk("rst_phi2", 8'(u_if0.phi2), 8'd0);
    chk("rst_err", 8'(u_if0.timing_err), 8'd0);
    step(2, "in_reset");
    rst_n = 1'b1;
    step(1, "rerun");
    chk("rerun_phi1", 8'(u_if0.phi1), 8'd1);
    chk("rerun_ts0", 8'(u_if0.tstate), 8'd0);
    chk("fast_phi1", 8'({u_if1.phi1, u_if1.phi2}), 8'd2);
    step(1, "rerun");
    chk("fast_phi2_strobes",
        8'({u_if1.phi1, u_if1.phi2, u_if1.dl_load, u_if1.cycle_end}), 8'b0111);
    step(3, "rerun");
    chk("fast_ts2", 8'(u_if1.tstate), 8'd2);
    chk("rerun_still_t0", 8'(u_if0.tstate), 8'd0);
    step(2, "rerun");
    chk("rerun_t1", 8'(u_if0.tstate), 8'd1);
    chk("rerun_sync", 8'(u_if0.sync), 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cycle_timer.md
Name: cycle_timer

Overview:
- Generates the two non-overlapping phase enables (phi1, phi2) and the per-cycle load strobe that drives the CPU's level-sensitive latches (data latch, instruction register).
- Sequences the instruction T-state (T0..T6), including SYNC, RDY read-stall and instruction-end restart.
- Sits directly upstream of the latch bank: every latch load input in the datapath is derived from this block's outputs.

Parameters:
- PHASE_LEN, 2, clk periods each phase enable is high (>=1)
- GAP, 1, dead clk periods after each phase, both phases low (>=0)
- Derived (localparam): CYC = 2*(PHASE_LEN+GAP), clk periods per CPU cycle; CW = $clog2(CYC), counter width

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- rdy  input  1  6502 RDY; low stalls read cycles
- rw  input  1  current cycle direction, 1=read 0=write
- end_instr  input  1  from decode; current cycle is the last of the instruction
- phi1  output  1  phase-1 enable
- phi2  output  1  phase-2 enable
- dl_load  output  1  one-clk strobe, data latch load
- ir_load  output  1  one-clk strobe, instruction register load
- cycle_end  output  1  one-clk strobe on last clk of a CPU cycle
- tstate  output  3  current T-state, 0..6
- sync  output  1  high for whole cycle when tstate==1
- stalled  output  1  current cycle is a RDY repeat
- timing_err  output  1  sticky; T6 reached without end_instr

Behaviour:
- Reset, asynchronous on rst_n low: counter = CYC-1; phi1, phi2, dl_load, ir_load, cycle_end, stalled and timing_err = 0; tstate = 0; sync = 0; first flag = 1.
- All outputs are registered. No combinational path from any input to any output.
- Counter: advances 0..CYC-1 and wraps to 0 every clk. The output values in a clk correspond to that clk's counter value c.
- phi1 = 1 for c in [0, PHASE_LEN-1].
- phi2 = 1 for c in [PHASE_LEN+GAP, 2*PHASE_LEN+GAP-1].
- Overlap: phi1 and phi2 are never high together. With GAP>=1 they are never adjacent.
- Strobes at the last phi2 clk (c = 2*PHASE_LEN+GAP-1):
  - dl_load pulses every cycle, including stalled cycles.
  - ir_load pulses only when sync=1 and the cycle is not stalled.
- cycle_end pulses at c = CYC-1.
- First edge after reset release: counter goes CYC-1 -> 0, tstate stays 0, first flag clears. No T-advance occurs on this edge.
- Cycle decision: inputs rdy, rw and end_instr are sampled on the clk where c = CYC-1, and the decision takes effect at the wrap to 0. Priority order:
  1. Stall: rdy=0 and rw=1. Cycle repeats, tstate holds, stalled=1 next cycle, end_instr ignored.
  2. Restart: end_instr=1. tstate goes to 1.
  3. Advance: tstate+1. At tstate==6 it holds 6 and sets timing_err (sticky until reset).
- Writes: rdy is ignored when rw=0; write cycles never stall.
- Cleared conditions: stalled clears on the first non-stall decision. sync = (tstate==1), registered, and changes only at the wrap.
- Reset mid-cycle: every output drops immediately. Restart follows the first-edge rule.

Decomposition:
- Package cpu_timing_pkg holds:
  - localparams T0..T6 (3-bit codes)
  - typedef tstate_t
  - function cyc_len(PHASE_LEN, GAP)
- Sub-module phase_counter(clk, rst_n, cnt, wrap): parameterised modulo-CYC counter with reset value CYC-1. cycle_timer decodes phases and strobes from cnt and runs the T-state logic itself.

Test Plan:
- Defaults (CYC=6), rdy=1, rw=1, end_instr=0, rst_n released:
  - phi1 high at c=0,1; phi2 high at c=3,4; dl_load at c=4; cycle_end at c=5.
  - tstate sequence 0,1,2,3,4,5,6,6; timing_err rises entering the second T6 cycle.
  - phi1&phi2 never both high.
- end_instr=1 sampled during T2 -> next cycle tstate=1, sync=1, ir_load pulses once at c=4; the following cycle is tstate=2.
- rdy=0 and rw=1 during T1 for 3 cycles:
  - tstate stays 1 and stalled=1 for 3 repeat cycles.
  - dl_load pulses every cycle; ir_load is suppressed on the repeats.
  - When rdy returns to 1, tstate=2.
- rdy=0 and rw=0 during T3 -> no stall: tstate 3 -> 4, stalled stays 0.
- rst_n low at c=3 of T4 -> all outputs 0 within that clk, tstate=0, timing_err cleared. After release: counter 0, phi1=1, tstate=0 for one full cycle, then 1.
- PHASE_LEN=1, GAP=0 (CYC=2):
  - phi1 and phi2 alternate each clk; dl_load and cycle_end on every odd clk.
  - tstate advances every 2 clks.
